uart_cfg_core: RTL

Runtime-configurable UART core: the parametrised successor to the fixed-format UART top level. It has a programmable baud divisor, parity mode (none/even/odd) and one or two stop bits, and carries per-byte receive error flags alongside the data plus a sticky overrun flag. It sits between the board I/O pins (rx/tx) and the user logic (switches, 7-segment, LEDs), with a TX FIFO and an RX FIFO in front of the serialisers.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/fifo.sv | 58 +++++
 rtl/uart_baud_div.sv | 28 ++
 rtl/uart_cfg_core.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity encodings, FSM states
// and the oversampling ratio.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned OS_BITS    = $clog2(OVERSAMPLE);

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // Encoding 11 is reserved and behaves like PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO; the output holds the last popped
// word while empty.
module fifo #(
    parameter int unsigned Width    = 8,
    parameter int unsigned AddrBits = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [Width-1:0] wdata,
    input  logic             rd,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned Depth = 2 ** AddrBits;
    localparam logic [AddrBits:0] FullCount = (AddrBits + 1)'(Depth);

    logic [Width-1:0]    mem_q [Depth];
    logic [AddrBits-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrBits:0]   count_q;
    logic [Width-1:0]    last_q;
    logic                do_wr, do_rd;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    assign do_rd = rd && !empty;
    // A read frees the slot being written, so write-when-full is allowed alongside a read.
    assign do_wr = wr && (!full || rd);
    assign rdata = empty ? last_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + 1'b1;
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_baud_div.sv
// Runtime-programmable oversample tick generator with a synchronous restart so
// each frame's first bit is a whole bit long.
module uart_baud_div #(
    parameter int unsigned DivBits = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DivBits-1:0] baud_div,
    input  logic               clear,
    output logic               tick
);
    logic [DivBits-1:0] cnt_q, limit;

    assign limit = (baud_div > DivBits'(1)) ? baud_div - DivBits'(1) : '0;
    // >= so that lowering the divisor mid-count wraps at once.
    assign tick  = (cnt_q >= limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DivBits'(1);
        end
    end

endmodule

// File: rtl/uart_cfg_core.sv
// UART with runtime baud divisor, parity mode and stop-bit count, fronted by
// TX and RX FIFOs; RX entries carry per-byte parity and framing flags.
module uart_cfg_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned FIFO_EXP  = 4,
    parameter int unsigned DIV_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_BITS-1:0]  baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 write_uart,
    input  logic [DATA_BITS-1:0] write_data,
    input  logic                 read_uart,
    output logic [DATA_BITS-1:0] read_data,
    output logic                 read_perr,
    output logic                 read_ferr,
    input  logic                 rx_data_in,
    output logic                 tx_data_out,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic                 rx_full,
    output logic                 rx_empty,
    output logic                 rx_overrun,
    input  logic                 err_clear
);
    localparam int unsigned IdxBits = $clog2(DATA_BITS);
    localparam logic [IdxBits-1:0] LastIdx = IdxBits'(DATA_BITS - 1);
    localparam logic [OS_BITS-1:0] OsLast  = OS_BITS'(OVERSAMPLE - 1);
    localparam logic [OS_BITS-1:0] OsStart = OS_BITS'(6);

    // ---------------- TX ----------------
    uart_state_e            tx_state_q, tx_state_d;
    logic [OS_BITS-1:0]     tx_os_q, tx_os_d;
    logic [IdxBits-1:0]     tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d, tx_head;
    logic                   tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
    logic                   tx_two_q, tx_two_d, tx_stop2_q, tx_stop2_d;
    logic                   tx_line_q, tx_line, tx_tick, tx_last, tx_load;

    uart_baud_div #(.DivBits(DIV_BITS)) u_tx_baud (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .clear    (tx_load),
        .tick     (tx_tick)
    );

    fifo #(.Width(DATA_BITS), .AddrBits(FIFO_EXP)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (write_uart),
        .wdata (write_data),
        .rd    (tx_load),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_os_d      = tx_os_q;
        tx_idx_d     = tx_idx_q;
        tx_shift_d   = tx_shift_q;
        tx_par_en_d  = tx_par_en_q;
        tx_par_bit_d = tx_par_bit_q;
        tx_two_d     = tx_two_q;
        tx_stop2_d   = tx_stop2_q;
        tx_line      = 1'b1;
        tx_load      = 1'b0;
        tx_last      = tx_tick && (tx_os_q == OsLast);
        if (tx_tick && (tx_state_q != StIdle)) tx_os_d = tx_os_q + 1'b1;

        unique case (tx_state_q)
            StIdle:  tx_load = !tx_empty;
            StStart: begin
                tx_line = 1'b0;
                if (tx_last) tx_state_d = StData;
            end
            StData: begin
                tx_line = tx_shift_q[0];
                if (tx_last) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_idx_d   = tx_idx_q + 1'b1;
                    if (tx_idx_q == LastIdx) tx_state_d = tx_par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                tx_line = tx_par_bit_q;
                if (tx_last) tx_state_d = StStop;
            end
            StStop: begin
                if (tx_last) begin
                    if (tx_two_q && !tx_stop2_q) begin
                        tx_stop2_d = 1'b1;
                    end else begin
                        tx_state_d = StIdle;
                        // Chain straight into the next start bit when more data waits.
                        tx_load    = !tx_empty;
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase

        if (tx_load) begin
            tx_state_d   = StStart;
            tx_shift_d   = tx_head;
            tx_idx_d     = '0;
            tx_os_d      = '0;
            tx_stop2_d   = 1'b0;
            tx_par_en_d  = parity_enabled(parity_mode);
            tx_par_bit_d = (^tx_head) ^ (parity_mode == PAR_ODD);
            tx_two_d     = two_stop;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q   <= StIdle;
            tx_os_q      <= '0;
            tx_idx_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_en_q  <= 1'b0;
            tx_par_bit_q <= 1'b0;
            tx_two_q     <= 1'b0;
            tx_stop2_q   <= 1'b0;
            tx_line_q    <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_os_q      <= tx_os_d;
            tx_idx_q     <= tx_idx_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_par_bit_q <= tx_par_bit_d;
            tx_two_q     <= tx_two_d;
            tx_stop2_q   <= tx_stop2_d;
            tx_line_q    <= tx_line;
        end
    end

    assign tx_data_out = tx_line_q;

    // ---------------- RX ----------------
    uart_state_e            rx_state_q, rx_state_d;
    logic [1:0]             rx_sync_q;
    logic [OS_BITS-1:0]     rx_os_q, rx_os_d;
    logic [IdxBits-1:0]     rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
    logic                   rx_perr_q, rx_perr_d, rx_ovr_q, rx_ovr_d;
    logic                   rx_s, rx_tick, rx_centre, rx_clear, rx_push, rx_drop;
    logic [DATA_BITS+1:0]   rx_rdata;

    assign rx_s = rx_sync_q[1];

    uart_baud_div #(.DivBits(DIV_BITS)) u_rx_baud (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .clear    (rx_clear),
        .tick     (rx_tick)
    );

    fifo #(.Width(DATA_BITS + 2), .AddrBits(FIFO_EXP)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (rx_push),
        .wdata ({!rx_s, rx_perr_q, rx_shift_q}),
        .rd    (read_uart),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign {read_ferr, read_perr, read_data} = rx_rdata;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_os_d     = rx_os_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        rx_par_en_d = rx_par_en_q;
        rx_odd_d    = rx_odd_q;
        rx_perr_d   = rx_perr_q;
        rx_clear    = 1'b0;
        rx_push     = 1'b0;
        rx_drop     = 1'b0;
        rx_centre   = rx_tick && (rx_os_q == OsLast);
        if (rx_tick && (rx_state_q != StIdle)) rx_os_d = rx_os_q + 1'b1;

        unique case (rx_state_q)
            StIdle: begin
                if (!rx_s) begin
                    rx_state_d  = StStart;
                    rx_clear    = 1'b1;
                    rx_os_d     = '0;
                    rx_idx_d    = '0;
                    rx_perr_d   = 1'b0;
                    rx_par_en_d = parity_enabled(parity_mode);
                    rx_odd_d    = (parity_mode == PAR_ODD);
                end
            end
            StStart: begin
                if (rx_tick && (rx_os_q == OsStart)) begin
                    rx_os_d    = '0;
                    rx_state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (rx_centre) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    rx_idx_d   = rx_idx_q + 1'b1;
                    if (rx_idx_q == LastIdx) rx_state_d = rx_par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (rx_centre) begin
                    rx_perr_d  = rx_s ^ (^rx_shift_q) ^ rx_odd_q;
                    rx_state_d = StStop;
                end
            end
            StStop: begin
                if (rx_centre) begin
                    rx_push    = !rx_full;
                    rx_drop    = rx_full;
                    rx_state_d = StIdle;
                end
            end
            default: rx_state_d = StIdle;
        endcase

        rx_ovr_d = rx_drop ? 1'b1 : (err_clear ? 1'b0 : rx_ovr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_q   <= 2'b11;
            rx_state_q  <= StIdle;
            rx_os_q     <= '0;
            rx_idx_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_en_q <= 1'b0;
            rx_odd_q    <= 1'b0;
            rx_perr_q   <= 1'b0;
            rx_ovr_q    <= 1'b0;
        end else begin
            rx_sync_q   <= {rx_sync_q[0], rx_data_in};
            rx_state_q  <= rx_state_d;
            rx_os_q     <= rx_os_d;
            rx_idx_q    <= rx_idx_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_en_q <= rx_par_en_d;
            rx_odd_q    <= rx_odd_d;
            rx_perr_q   <= rx_perr_d;
            rx_ovr_q    <= rx_ovr_d;
        end
    end

    assign rx_overrun = rx_ovr_q;

endmodule
